// File: rtl/mem_access_ctrl.sv
// Memory-access stage: takes one op from execute, issues an optional word/byte
// memory transaction with a bounded wait, and presents the writeback result.

`ifndef REG_SIZE
`define REG_SIZE 32
`endif

`ifndef ALUOP_ADD
`define ALUOP_ADD  5'd0
`define ALUOP_SUB  5'd1
`define ALUOP_AND  5'd2
`define ALUOP_OR   5'd3
`define ALUOP_XOR  5'd4
`define ALUOP_SLL  5'd5
`define ALUOP_SRL  5'd6
`define ALUOP_SRA  5'd7
`define ALUOP_SLT  5'd8
`define ALUOP_LUI  5'd9
`define ALUOP_LDB  5'd10
`define ALUOP_LDW  5'd11
`define ALUOP_STB  5'd12
`define ALUOP_STW  5'd13
`define ALUOP_BEQ  5'd14
`define ALUOP_JUMP 5'd15
`endif

module mem_access_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int REG_SIZE    = `REG_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_aluop,
  input  logic [REG_SIZE-1:0] in_addr,
  input  logic [REG_SIZE-1:0] in_wdata,
  input  logic [4:0]          in_rd,
  input  logic                in_overflow,
  output logic                mem_req,
  output logic                mem_we,
  output logic [REG_SIZE-1:0] mem_addr,
  output logic [REG_SIZE-1:0] mem_wdata,
  output logic [3:0]          mem_be,
  input  logic [REG_SIZE-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_SIZE-1:0] out_data,
  output logic [4:0]          out_rd,
  output logic                out_regwrite,
  output logic                exc_ovf,
  output logic                exc_bus
);

  localparam logic [4:0] OP_ADD  = `ALUOP_ADD;
  localparam logic [4:0] OP_SUB  = `ALUOP_SUB;
  localparam logic [4:0] OP_AND  = `ALUOP_AND;
  localparam logic [4:0] OP_OR   = `ALUOP_OR;
  localparam logic [4:0] OP_XOR  = `ALUOP_XOR;
  localparam logic [4:0] OP_SLL  = `ALUOP_SLL;
  localparam logic [4:0] OP_SRL  = `ALUOP_SRL;
  localparam logic [4:0] OP_SRA  = `ALUOP_SRA;
  localparam logic [4:0] OP_SLT  = `ALUOP_SLT;
  localparam logic [4:0] OP_LUI  = `ALUOP_LUI;
  localparam logic [4:0] OP_LDB  = `ALUOP_LDB;
  localparam logic [4:0] OP_LDW  = `ALUOP_LDW;
  localparam logic [4:0] OP_STB  = `ALUOP_STB;
  localparam logic [4:0] OP_STW  = `ALUOP_STW;
  localparam logic [4:0] OP_BEQ  = `ALUOP_BEQ;
  localparam logic [4:0] OP_JUMP = `ALUOP_JUMP;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MEMREQ = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  // The counter never holds MEM_TIMEOUT itself: the cycle that would reach it leaves MEMREQ.
  localparam int             CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic [REG_SIZE-1:0] addr_q;
  logic [REG_SIZE-1:0] wdata_q;
  logic [3:0]          be_q;
  logic                load_q;
  logic                byte_q;
  logic [1:0]          sel_q;
  logic [REG_SIZE-1:0] data_q;
  logic [4:0]          rd_q;
  logic                rw_q;
  logic                ovf_q;
  logic                bus_q;

  logic                accept;
  logic                dec_mem;
  logic                dec_store;
  logic                dec_byte;
  logic                dec_rw;
  logic                dec_ovf;
  logic [3:0]          next_be;
  logic [REG_SIZE-1:0] next_wdata;
  logic [7:0]          lane;
  logic [REG_SIZE-1:0] load_value;

  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise an unlisted opcode would leave it unassigned and infer a latch.
  always_comb begin
    dec_mem   = 1'b0;
    dec_store = 1'b0;
    dec_byte  = 1'b0;
    dec_rw    = 1'b0;
    dec_ovf   = 1'b0;
    case (in_aluop)
      OP_ADD, OP_SUB: begin
        dec_rw  = !in_overflow;
        dec_ovf = in_overflow;
      end
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_LUI: dec_rw = 1'b1;
      OP_LDB: begin
        dec_mem  = 1'b1;
        dec_byte = 1'b1;
      end
      OP_LDW: dec_mem = 1'b1;
      OP_STB: begin
        dec_mem   = 1'b1;
        dec_store = 1'b1;
        dec_byte  = 1'b1;
      end
      OP_STW: begin
        dec_mem   = 1'b1;
        dec_store = 1'b1;
      end
      OP_BEQ, OP_JUMP: dec_rw = 1'b0;
      default: dec_rw = 1'b0;
    endcase
  end

  // Byte loads still read the whole word; only byte stores narrow the enables.
  always_comb begin
    next_be    = 4'b1111;
    next_wdata = in_wdata;
    if (dec_store && dec_byte) begin
      next_be    = 4'b0001 << in_addr[1:0];
      next_wdata = {(REG_SIZE/8){in_wdata[7:0]}};
    end
  end

  always_comb begin
    lane       = mem_rdata[{sel_q, 3'b000} +: 8];
    load_value = byte_q ? {{(REG_SIZE-8){lane[7]}}, lane} : mem_rdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      load_q  <= 1'b0;
      byte_q  <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      ovf_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            rd_q <= in_rd;
            if (dec_mem) begin
              state_q <= MEMREQ;
              cnt_q   <= '0;
              we_q    <= dec_store;
              addr_q  <= {in_addr[REG_SIZE-1:2], 2'b00};
              be_q    <= next_be;
              wdata_q <= next_wdata;
              load_q  <= !dec_store;
              byte_q  <= dec_byte;
              sel_q   <= in_addr[1:0];
            end else begin
              state_q <= HOLD;
              data_q  <= in_addr;
              rw_q    <= dec_rw;
              ovf_q   <= dec_ovf;
              bus_q   <= 1'b0;
            end
          end else if ((state_q == HOLD) && out_ready) begin
            state_q <= IDLE;
          end
        end
        MEMREQ: begin
          // An ack on the final allowed cycle still completes the access.
          if (mem_ack) begin
            state_q <= HOLD;
            data_q  <= load_q ? load_value : '0;
            rw_q    <= load_q;
            ovf_q   <= 1'b0;
            bus_q   <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HOLD;
            data_q  <= '0;
            rw_q    <= 1'b0;
            ovf_q   <= 1'b0;
            bus_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req      = (state_q == MEMREQ);
  assign mem_we       = we_q && mem_req;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_be       = be_q;
  assign out_valid    = (state_q == HOLD);
  assign out_data     = data_q;
  assign out_rd       = rd_q;
  assign out_regwrite = rw_q && out_valid;
  assign exc_ovf      = ovf_q && out_valid;
  assign exc_bus      = bus_q && out_valid;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// ops compared against an arithmetic model of the writeback/memory rules.

module tb_mem_access_ctrl;

  localparam int T = 15;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_LUI  = 5'd9;
  localparam logic [4:0] OP_LDB  = 5'd10;
  localparam logic [4:0] OP_LDW  = 5'd11;
  localparam logic [4:0] OP_STB  = 5'd12;
  localparam logic [4:0] OP_STW  = 5'd13;
  localparam logic [4:0] OP_BEQ  = 5'd14;
  localparam logic [4:0] OP_JUMP = 5'd15;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_aluop;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        in_overflow;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic        exc_ovf;
  logic        exc_bus;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_overflow(in_overflow),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .exc_ovf(exc_ovf), .exc_bus(exc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mem_seen;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stable;
    int          cycles;
    int          waited;
    logic        valid;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        ovf;
    logic        bus;
  } obs_t;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cycles;
    logic [31:0] data;
    logic        regwrite;
    logic        ovf;
    logic        bus;
  } exp_t;

  // Expected behaviour derived straight from the op's rules, with a memory that
  // acks during the (ack_lat)th request cycle counted from zero.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic ovf, input int ack_lat);
    exp_t        e;
    int unsigned b;
    logic        arith_ovf;
    e = '{default: 0};
    e.is_mem = (op == OP_LDB) || (op == OP_LDW) || (op == OP_STB) || (op == OP_STW);
    if (e.is_mem) begin
      e.addr   = addr - (addr % 4);
      e.we     = (op == OP_STB) || (op == OP_STW);
      e.be     = (op == OP_STB) ? 4'(1 << (addr % 4)) : 4'hF;
      e.wdata  = (op == OP_STB) ? wdata[7:0] * 32'h0101_0101 : wdata;
      e.cycles = (ack_lat < T) ? ack_lat + 1 : T;
      e.bus    = (ack_lat >= T);
      if (!e.bus && op == OP_LDW) begin
        e.data     = rdata;
        e.regwrite = 1'b1;
      end else if (!e.bus && op == OP_LDB) begin
        b          = (rdata / (32'd1 << (8 * (addr % 4)))) % 256;
        e.data     = (b >= 128) ? b - 256 : b;
        e.regwrite = 1'b1;
      end
    end else begin
      arith_ovf  = ((op == OP_ADD) || (op == OP_SUB)) && ovf;
      e.data     = addr;
      e.ovf      = arith_ovf;
      e.regwrite = !((op == OP_BEQ) || (op == OP_JUMP) || (op > 5'd15) || arith_ovf);
    end
    return e;
  endfunction

  // Presents one op with out_ready=1, plays the memory side, and records what the DUT did.
  task automatic do_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic ovf, input int ack_lat,
                       input logic [31:0] rdata, output obs_t o);
    o = '{default: 0};
    in_aluop    = op;
    in_addr     = addr;
    in_wdata    = wdata;
    in_rd       = rd;
    in_overflow = ovf;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    while (!in_ready && o.waited < 50) begin
      @(posedge clk); #1;
      o.waited++;
    end
    if (o.waited >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: in_ready stayed %b, wanted 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (mem_req) begin
      o.mem_seen = 1'b1;
      o.we       = mem_we;
      o.addr     = mem_addr;
      o.be       = mem_be;
      o.wdata    = mem_wdata;
      o.stable   = 1'b1;
      for (int k = 0; k < 40; k++) begin
        if (mem_we !== o.we || mem_addr !== o.addr || mem_be !== o.be || mem_wdata !== o.wdata)
          o.stable = 1'b0;
        if (k == ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        o.cycles  = k + 1;
        if (!mem_req) break;
      end
    end
    o.valid    = out_valid;
    o.data     = out_data;
    o.rd       = out_rd;
    o.regwrite = out_regwrite;
    o.ovf      = exc_ovf;
    o.bus      = exc_bus;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_aluop = '0; in_addr = '0; in_wdata = '0;
    in_rd = '0; in_overflow = 1'b0; mem_rdata = '0; mem_ack = 1'b0; out_ready = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem: req %b we %b want 0 0", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin errors++; $display("FAIL reset_mem_bus: addr %h wdata %h be %b want 0", mem_addr, mem_wdata, mem_be); end
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd0 || out_regwrite !== 1'b0) begin errors++; $display("FAIL reset_out: valid %b data %h rd %0d rw %b want all 0", out_valid, out_data, out_rd, out_regwrite); end
    checks++; if (exc_ovf !== 1'b0 || exc_bus !== 1'b0) begin errors++; $display("FAIL reset_exc: ovf %b bus %b want 0 0", exc_ovf, exc_bus); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs straight after reset release, so it also proves the first edge accepts.
  task automatic test_alu();
    obs_t o;
    do_op(OP_ADD, 32'h10, 32'h0, 5'd3, 1'b0, 0, 32'h0, o);
    checks++; if (o.waited !== 0 || o.mem_seen !== 1'b0) begin errors++; $display("FAIL alu_accept: waited %0d mem %b want 0 0", o.waited, o.mem_seen); end
    checks++; if (o.valid !== 1'b1 || o.data !== 32'h10 || o.rd !== 5'd3 || o.regwrite !== 1'b1) begin errors++; $display("FAIL alu_add: valid %b data %h rd %0d rw %b want 1 00000010 3 1", o.valid, o.data, o.rd, o.regwrite); end
    do_op(OP_BEQ, 32'h1234, 32'h0, 5'd7, 1'b0, 0, 32'h0, o);
    checks++; if (o.valid !== 1'b1 || o.data !== 32'h1234 || o.regwrite !== 1'b0) begin errors++; $display("FAIL alu_beq: valid %b data %h rw %b want 1 00001234 0", o.valid, o.data, o.regwrite); end
    do_op(5'd27, 32'h55, 32'h0, 5'd9, 1'b0, 0, 32'h0, o);
    checks++; if (o.valid !== 1'b1 || o.mem_seen !== 1'b0 || o.data !== 32'h55 || o.regwrite !== 1'b0) begin errors++; $display("FAIL alu_unknown: valid %b mem %b data %h rw %b want 1 0 00000055 0", o.valid, o.mem_seen, o.data, o.regwrite); end
  endtask

  task automatic test_ldb();
    obs_t o;
    do_op(OP_LDB, 32'h102, 32'h0, 5'd4, 1'b0, 2, 32'h00F0_0000, o);
    checks++; if (o.mem_seen !== 1'b1 || o.addr !== 32'h100 || o.we !== 1'b0) begin errors++; $display("FAIL ldb_req: seen %b addr %h we %b want 1 00000100 0", o.mem_seen, o.addr, o.we); end
    checks++; if (o.cycles !== 3 || o.stable !== 1'b1) begin errors++; $display("FAIL ldb_timing: cycles %0d stable %b want 3 1", o.cycles, o.stable); end
    checks++; if (o.valid !== 1'b1 || o.data !== 32'hFFFF_FFF0 || o.regwrite !== 1'b1 || o.rd !== 5'd4) begin errors++; $display("FAIL ldb_result: valid %b data %h rw %b rd %0d want 1 fffffff0 1 4", o.valid, o.data, o.regwrite, o.rd); end
  endtask

  task automatic test_stb();
    obs_t o;
    do_op(OP_STB, 32'h203, 32'h0000_00AB, 5'd6, 1'b0, 0, 32'h0, o);
    checks++; if (o.be !== 4'b1000 || o.we !== 1'b1 || o.wdata !== 32'hABAB_ABAB || o.addr !== 32'h200) begin errors++; $display("FAIL stb_req: be %b we %b wdata %h addr %h want 1000 1 abababab 00000200", o.be, o.we, o.wdata, o.addr); end
    checks++; if (o.valid !== 1'b1 || o.regwrite !== 1'b0 || o.data !== 32'd0 || o.bus !== 1'b0) begin errors++; $display("FAIL stb_result: valid %b rw %b data %h bus %b want 1 0 0 0", o.valid, o.regwrite, o.data, o.bus); end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_op(OP_LDW, 32'h400, 32'h0, 5'd8, 1'b0, 99, 32'h0, o);
    checks++; if (o.cycles !== T || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_len: cycles %0d req %b want %0d 0", o.cycles, mem_req, T); end
    checks++; if (o.valid !== 1'b1 || o.bus !== 1'b1 || o.regwrite !== 1'b0 || o.data !== 32'd0) begin errors++; $display("FAIL timeout_result: valid %b bus %b rw %b data %h want 1 1 0 0", o.valid, o.bus, o.regwrite, o.data); end
    do_op(OP_LDW, 32'h404, 32'h0, 5'd8, 1'b0, T - 1, 32'hCAFE_F00D, o);
    checks++; if (o.cycles !== T || o.bus !== 1'b0 || o.data !== 32'hCAFE_F00D || o.regwrite !== 1'b1) begin errors++; $display("FAIL ack_at_limit: cycles %0d bus %b data %h rw %b want %0d 0 cafef00d 1", o.cycles, o.bus, o.data, o.regwrite, T); end
    do_op(OP_STW, 32'h408, 32'h1111_2222, 5'd8, 1'b0, T, 32'h0, o);
    checks++; if (o.cycles !== T || o.bus !== 1'b1) begin errors++; $display("FAIL ack_past_limit: cycles %0d bus %b want %0d 1", o.cycles, o.bus, T); end
  endtask

  task automatic test_ovf_stall();
    obs_t o;
    do_op(OP_SUB, 32'h8000_0001, 32'h0, 5'd12, 1'b1, 0, 32'h0, o);
    checks++; if (o.ovf !== 1'b1 || o.regwrite !== 1'b0 || o.data !== 32'h8000_0001) begin errors++; $display("FAIL ovf_result: ovf %b rw %b data %h want 1 0 80000001", o.ovf, o.regwrite, o.data); end
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || exc_ovf !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h8000_0001 || out_rd !== 5'd12) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid %b ovf %b in_ready %b data %h rd %0d want 1 1 0 80000001 12", i, out_valid, exc_ovf, in_ready, out_data, out_rd);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: in_ready %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] vals [3] = '{32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 3; i++) begin
      do_op(OP_AND, vals[i], 32'h0, 5'(i + 20), 1'b0, 0, 32'h0, o);
      checks++;
      if (o.waited !== 0 || o.valid !== 1'b1 || o.data !== vals[i] || o.rd !== 5'(i + 20)) begin
        errors++;
        $display("FAIL b2b[%0d]: waited %0d valid %b data %h rd %0d want 0 1 %h %0d", i, o.waited, o.valid, o.data, o.rd, vals[i], i + 20);
      end
    end
    do_op(OP_STW, 32'h0000_0ABE, 32'h1357_9BDF, 5'd1, 1'b0, 1, 32'h0, o);
    checks++; if (o.waited !== 0 || o.addr !== 32'h0000_0ABC || o.be !== 4'hF || o.wdata !== 32'h1357_9BDF) begin errors++; $display("FAIL b2b_stw: waited %0d addr %h be %b wdata %h want 0 00000abc 1111 13579bdf", o.waited, o.addr, o.be, o.wdata); end
  endtask

  task automatic test_stray_ack();
    obs_t o;
    do_op(OP_LUI, 32'h7777_0000, 32'h0, 5'd2, 1'b0, 0, 32'h0, o);
    out_ready = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h7777_0000) begin errors++; $display("FAIL stray_ack_hold: req %b valid %b data %h want 0 1 77770000", mem_req, out_valid, out_data); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_to_idle: valid %b in_ready %b want 0 1", out_valid, in_ready); end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stray_ack_idle: req %b valid %b want 0 0", mem_req, out_valid); end
  endtask

  task automatic test_reset_mid();
    in_aluop = OP_LDW; in_addr = 32'h600; in_rd = 5'd5; in_overflow = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: req %b want 1", mem_req); end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_async: req %b we %b valid %b in_ready %b want 0 0 0 1", mem_req, mem_we, out_valid, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_discard: req %b valid %b in_ready %b want 0 0 1", mem_req, out_valid, in_ready); end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [4:0]  op;
    logic [31:0] addr, wdata, rdata;
    logic        ovf;
    int          lat;
    logic [4:0]  rd;
    for (int n = 0; n < 60; n++) begin
      op    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(10, 13)) : 5'($urandom_range(0, 31));
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      ovf   = 1'($urandom_range(0, 1));
      lat   = $urandom_range(0, T + 1);
      rd    = 5'($urandom);
      e     = model(op, addr, wdata, rdata, ovf, lat);
      do_op(op, addr, wdata, rd, ovf, lat, rdata, o);
      checks++;
      if (o.valid !== 1'b1 || o.data !== e.data || o.rd !== rd || o.regwrite !== e.regwrite || o.ovf !== e.ovf || o.bus !== e.bus) begin
        errors++;
        $display("FAIL rand_out[%0d] op %0d: valid %b data %h rd %0d rw %b ovf %b bus %b want 1 %h %0d %b %b %b",
                 n, op, o.valid, o.data, o.rd, o.regwrite, o.ovf, o.bus, e.data, rd, e.regwrite, e.ovf, e.bus);
      end
      checks++;
      if (o.mem_seen !== e.is_mem) begin
        errors++;
        $display("FAIL rand_mem_seen[%0d] op %0d: got %b want %b", n, op, o.mem_seen, e.is_mem);
      end else if (e.is_mem) begin
        checks++;
        if (o.addr !== e.addr || o.we !== e.we || o.cycles !== e.cycles || o.stable !== 1'b1) begin
          errors++;
          $display("FAIL rand_mem[%0d] op %0d: addr %h we %b cycles %0d stable %b want %h %b %0d 1",
                   n, op, o.addr, o.we, o.cycles, o.stable, e.addr, e.we, e.cycles);
        end
        if (op != OP_LDB) begin
          checks++;
          if (o.be !== e.be || (e.we && o.wdata !== e.wdata)) begin
            errors++;
            $display("FAIL rand_be[%0d] op %0d: be %b wdata %h want %b %h", n, op, o.be, o.wdata, e.be, e.wdata);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ldb();
    test_stb();
    test_timeout();
    test_ovf_stall();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles the block waits for mem_ack before a bus error.
REQ-002 Parameter `REG_SIZE (from define.v), default 32, data/address width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  execute stage presents an op.
REQ-006 in_ready  out  1  block accepts the op this cycle.
REQ-007 in_aluop  in  5  `ALUOP_* code of the op.
REQ-008 in_addr  in  32  ALU result (address for LDB/LDW/STB/STW, value otherwise).
REQ-009 in_wdata  in  32  store data.
REQ-010 in_rd  in  5  destination register.
REQ-011 in_overflow  in  1  ALU overflow flag.
REQ-012 mem_req / mem_we  out  1 / 1  memory request strobe / write enable.
REQ-013 mem_addr / mem_wdata / mem_be  out  32 / 32 / 4  word address, write data, byte enables.
REQ-014 mem_rdata / mem_ack  in  32 / 1  read data / one-cycle completion pulse.
REQ-015 out_valid / out_ready  out / in  1 / 1  writeback handshake.
REQ-016 out_data / out_rd / out_regwrite  out  32 / 5 / 1  writeback value, register, write enable.
REQ-017 exc_ovf / exc_bus  out  1 / 1  overflow / bus-error exception, qualified by out_valid.

Function
REQ-018 Transfer on either port occurs only when valid and ready are both high at a rising edge.
REQ-019 FSM states: IDLE, MEMREQ, HOLD.
REQ-020 in_ready is high in IDLE, and in HOLD when out_ready is high; low in MEMREQ.
REQ-021 IDLE/HOLD accept of non-memory op -> HOLD next cycle, out_data=in_addr, out_rd=in_rd, out_regwrite=1 except BEQ/JUMP (0); latency 1 cycle.
REQ-022 ADD/SUB with in_overflow=1 -> out_regwrite=0, exc_ovf=1; other fields as REQ-021.
REQ-023 Accept of LDB/LDW/STB/STW -> MEMREQ next cycle with mem_req=1; mem_addr={in_addr[31:2],2'b00}.
REQ-024 LDW/STW: mem_be=4'b1111; STW mem_wdata=in_wdata.
REQ-025 STB: mem_be=4'b0001<<in_addr[1:0]; mem_wdata=in_wdata[7:0] replicated 4 times.
REQ-026 mem_we=1 for stores, 0 for loads; mem_req/mem_we/mem_addr/mem_be/mem_wdata stable throughout MEMREQ.
REQ-027 MEMREQ with mem_ack=1 -> mem_req deasserts next cycle, state HOLD.
REQ-028 LDW result: out_data=mem_rdata; LDB: out_data=sign-extended byte mem_rdata[8*a+7:8*a], a=in_addr[1:0] latched at accept.
REQ-029 Loads out_regwrite=1; stores out_regwrite=0, out_data=0.
REQ-030 Wait counter resets to 0 on MEMREQ entry, increments each MEMREQ cycle without ack.
REQ-031 Counter reaching MEM_TIMEOUT without ack -> mem_req drops, HOLD with exc_bus=1, out_regwrite=0, out_data=0.
REQ-032 mem_ack in the same cycle the counter reaches MEM_TIMEOUT: ack wins, no bus error.
REQ-033 HOLD with out_ready=0 holds all out_* stable; in_ready=0.
REQ-034 HOLD with out_ready=1 and in_valid=1: back-to-back accept, no bubble; with in_valid=0 -> IDLE, out_valid=0.
REQ-035 mem_ack outside MEMREQ is ignored.
REQ-036 Unknown aluop treated as non-memory op with out_regwrite=0.

Reset
REQ-037 rst_n low immediately forces IDLE, counter 0, and all outputs 0 except in_ready=1.
REQ-038 Reset during MEMREQ drops mem_req asynchronously; the pending op is discarded with no writeback.
REQ-039 First accept possible at the first rising edge after rst_n deasserts.

Verification
REQ-040 ADD in_addr=0x00000010, in_rd=3, out_ready=1 -> next cycle out_valid=1, out_data=0x10, out_rd=3, out_regwrite=1.
REQ-041 LDB in_addr=0x00000102, mem_rdata=0x00F00000, ack after 2 cycles -> mem_addr=0x100, out_data=0xFFFFFFF0, out_regwrite=1.
REQ-042 STB in_addr=0x00000203, in_wdata=0xAB -> mem_be=4'b1000, mem_we=1, mem_wdata=0xABABABAB, out_regwrite=0.
REQ-043 LDW, no ack -> after 15 cycles mem_req=0, out_valid=1, exc_bus=1, out_regwrite=0.
REQ-044 SUB in_overflow=1 with out_ready=0 for 3 cycles -> exc_ovf=1 held stable, in_ready=0 until out_ready=1.
REQ-045 rst_n low mid-MEMREQ -> mem_req=0 at once, out_valid=0, in_ready=1 after release.
